// File: rtl/multu_32bits_pkg.sv
// rtl/multu_32bits_pkg.sv - funct codes, FSM state encoding and shift-add helper for the MULTU unit
package multu_32bits_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MULT = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // One radix-2 step: conditional add into the upper half (carry kept in bit 64), then shift right.
  function automatic logic [64:0] shift_add_step(input logic [64:0] prod,
                                                 input logic [31:0] mcand);
    logic [64:0] acc;
    acc = prod;
    if (prod[0]) begin
      acc[64:32] = {1'b0, prod[63:32]} + {1'b0, mcand};
    end
    return acc >> 1;
  endfunction

endpackage

// File: rtl/multu_32bits.sv
// rtl/multu_32bits.sv - 32-cycle sequential unsigned multiplier with HI/LO readout
module multu_32bits
  import multu_32bits_pkg::*;
#(
  parameter int WIDTH = multu_32bits_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       inSignal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut
);

  state_t             state;
  logic [4:0]         count;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [2*WIDTH:0]   prod;
  logic [2*WIDTH:0]   prod_step;

  assign prod_step = shift_add_step(prod, mcand);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= '0;
      prod  <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (inSignal == FN_MULTU)) begin
            mcand <= a;
            prod  <= {{(WIDTH+1){1'b0}}, b};
            count <= '0;
            state <= S_MULT;
          end
        end
        S_MULT: begin
          prod  <= prod_step;
          count <= count + 5'd1;
          // HI/LO take the result of the final step directly, so they change exactly once per multiply.
          if (count == 5'd31) begin
            hi    <= prod_step[2*WIDTH-1:WIDTH];
            lo    <= prod_step[WIDTH-1:0];
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    dataOut = '0;
    case (inSignal)
      FN_MFHI: dataOut = hi;
      FN_MFLO: dataOut = lo;
      default: dataOut = '0;
    endcase
  end

endmodule

// File: tb/tb_multu_32bits.sv
// tb/tb_multu_32bits.sv - scoreboard bench for multu_32bits with randomized operands
module tb_multu_32bits;

  localparam logic [5:0] T_MULTU = 6'b011001;
  localparam logic [5:0] T_MFHI  = 6'b010000;
  localparam logic [5:0] T_MFLO  = 6'b010010;
  localparam logic [5:0] T_ADD   = 6'b100000;

  typedef struct {
    int          cyc;
    logic [63:0] prod;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [5:0]  inSignal;
  logic        busy;
  logic        done;
  logic [31:0] dataOut;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [63:0] model_res = 64'd0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multu_32bits dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .inSignal (inSignal),
    .busy     (busy),
    .done     (done),
    .dataOut  (dataOut)
  );

  function automatic logic [31:0] sel(input logic [63:0] r, input logic [5:0] fn);
    if (fn == T_MFHI) return r[63:32];
    if (fn == T_MFLO) return r[31:0];
    return 32'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Completion monitor: every done pulse must match the oldest outstanding multiply.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done cycle", 64'(cyc), 64'(e.cyc));
        check("done readout", 64'(dataOut), 64'(sel(e.prod, inSignal)));
      end
    end
  end

  task automatic read_result(input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    inSignal = T_MFHI;
    sample();
    check("mfhi", 64'(dataOut), 64'(exp_hi));
    check("mfhi model", 64'(dataOut), 64'(model_res[63:32]));
    inSignal = T_MFLO;
    sample();
    check("mflo", 64'(dataOut), 64'(exp_lo));
    check("mflo model", 64'(dataOut), 64'(model_res[31:0]));
  endtask

  task automatic idle_probe(input logic [5:0] fn);
    inSignal = fn;
    start    = 1'b1;
    a        = $urandom;
    b        = $urandom;
    sample();
    check("idle readout", 64'(dataOut), 64'(sel(model_res, fn)));
    check("idle busy", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    sample();
    check("idle no accept", 64'(busy), 64'd0);
    check("idle hold", 64'(dataOut), 64'(sel(model_res, fn)));
  endtask

  task automatic do_mult(input logic [31:0] oa, input logic [31:0] ob,
                         input bit interfere, input bit abort);
    logic [63:0] prod;
    int          n;
    prod     = 64'(oa) * 64'(ob);
    start    = 1'b1;
    inSignal = T_MULTU;
    a        = oa;
    b        = ob;
    tick();
    n = cyc;
    exp_q.push_back('{n + 32, prod});
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i <= 32; i++) begin
      if (abort && i == 15) begin
        reset    = 1'b1;
        inSignal = T_MFHI;
        tick();
        exp_q.delete();
        model_res = 64'd0;
        sample();
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort mfhi", 64'(dataOut), 64'd0);
        tick();
        inSignal = T_MFLO;
        sample();
        check("abort mflo", 64'(dataOut), 64'd0);
        reset = 1'b0;
        return;
      end
      inSignal = ($urandom_range(0, 1) == 1) ? T_MFHI : T_MFLO;
      if (interfere && i == 10) begin
        start = 1'b1;
        a     = 32'd7;
        b     = 32'd7;
      end else begin
        start = 1'b0;
      end
      sample();
      check("busy during op", 64'(busy), 64'd1);
      if (i < 32) check("old result held", 64'(dataOut), 64'(sel(model_res, inSignal)));
      tick();
    end
    start     = 1'b0;
    model_res = prod;
    sample();
    check("idle after done busy", 64'(busy), 64'd0);
    check("single done pulse", 64'(done), 64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    inSignal = T_MULTU;
    repeat (3) tick();
    inSignal = T_MFHI;
    sample();
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset mfhi", 64'(dataOut), 64'd0);
    inSignal = T_MFLO;
    sample();
    check("reset mflo", 64'(dataOut), 64'd0);
    start = 1'b0;
    reset = 1'b0;

    do_mult(32'd3, 32'd5, 1'b0, 1'b0);
    read_result(32'h0000_0000, 32'h0000_000F);

    idle_probe(T_ADD);
    idle_probe(T_MFLO);
    idle_probe(T_MFHI);

    do_mult(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0);
    read_result(32'h0000_0001, 32'h0000_0000);

    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    read_result(32'hFFFF_FFFE, 32'h0000_0001);

    do_mult($urandom, $urandom, 1'b0, 1'b1);
    do_mult(32'd2, 32'd9, 1'b0, 1'b0);
    read_result(32'h0000_0000, 32'h0000_0012);

    for (int k = 0; k < 20; k++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 5 == 1) ra = 32'hFFFF_FFFF;
      if (k % 7 == 2) rb = 32'd0;
      do_mult(ra, rb, ($urandom_range(0, 1) == 1), 1'b0);
      if (k % 4 == 3) read_result(model_res[63:32], model_res[31:0]);
    end

    repeat (4) tick();
    check("no outstanding ops", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multu_32bits.md
MULTU_32BITS -- requirements
Module: multu_32bits

Interface
REQ-001 Parameter: WIDTH, 32, operand width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; the block has one clock domain.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request strobe, sampled on the clk rising edge.
REQ-005 Port: a  input  32  multiplicand; unsigned.
REQ-006 Port: b  input  32  multiplier; unsigned.
REQ-007 Port: inSignal  input  6  MIPS funct code, shared with the ALU result path.
REQ-008 Port: busy  output  1  high while a multiply is in progress.
REQ-009 Port: done  output  1  one-cycle pulse when HI/LO is updated.
REQ-010 Port: dataOut  output  32  readout: HI for MFHI, LO for MFLO, 0 otherwise.

Function
REQ-011 Funct codes:
  - MULTU = 6'b011001.
  - MFHI = 6'b010000.
  - MFLO = 6'b010010.
REQ-012 FSM states: IDLE, MULT, DONE.
REQ-013 Accept condition: start=1 in IDLE with inSignal=MULTU.
  - On accept, latch mcand<=a and prod[64:0]<={33'b0,b}.
  - Set count<=0 and move to MULT.
REQ-014 A start in IDLE with any other funct code is ignored; state is unchanged.
REQ-015 Each MULT cycle performs one shift-add step:
  - If prod[0]=1, prod[64:32] <= prod[63:32] + mcand, computed 33 bits wide with the carry kept.
  - Then shift prod right by 1.
  - Increment count.
REQ-016 After the 32nd MULT cycle (count=31), go to DONE; HI<=prod[63:32] and LO<=prod[31:0] are loaded on that edge.
REQ-017 DONE lasts one cycle with done=1, then returns to IDLE.
REQ-018 Latency: done is high in cycle N+33, where N is the accept edge.
  - The earliest next accept is cycle N+34.
REQ-019 busy=1 in MULT and DONE; busy=0 in IDLE.
REQ-020 start while busy=1 is ignored, and a and b are not re-sampled.
REQ-021 HI and LO change only at completion.
  - MFHI/MFLO during busy return the previous result.
REQ-022 dataOut is combinational from HI/LO and inSignal, with zero latency.
  - In the completion cycle (DONE), dataOut already shows the new result.
REQ-023 The result is the exact 64-bit unsigned product; there is no overflow or truncation.

Reset
REQ-024 Reset overrides every other input, including start, in the same cycle.
  - Reset mid-operation aborts the multiply; no done pulse is generated.
REQ-025 Reset values:
  - state=IDLE, busy=0, done=0.
  - HI=0, LO=0, so dataOut=0 for any funct code.
  - count=0, prod=0, mcand=0.
REQ-026 The first accept is possible on the first edge after reset deasserts.

Structure
REQ-027 Shared package contents:
  - The funct-code constants: AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, MULTU, MFHI, MFLO.
  - The FSM state typedef.
  - The WIDTH constant.
REQ-028 A single module is sufficient.
  - The FSM and datapath are inline.
  - The 33-bit adder is one expression; no sub-module is required.
REQ-029 The iteration counter is 5 bits; completion is detected at count=31.
REQ-030 RTL size: 120-250 lines.

Verification
REQ-031 a=3, b=5, MULTU start at edge N:
  - busy goes high at N+1 and done pulses at N+33.
  - MFLO -> 0x0000000F; MFHI -> 0x00000000.
REQ-032 a=b=0xFFFFFFFF:
  - MFHI -> 0xFFFFFFFE.
  - MFLO -> 0x00000001.
REQ-033 Previous result HI=0, LO=0x0F; start with a=0x10000, b=0x10000:
  - MFLO reads 0x0F throughout busy.
  - After done, MFHI -> 0x00000001 and MFLO -> 0x00000000.
REQ-034 A second start with a=7, b=7 at N+10:
  - It is ignored; the result remains that of the first operands.
  - done pulses exactly once, at N+33.
REQ-035 Reset asserted at N+15 of a multiply:
  - busy=0, dataOut=0 under MFHI and MFLO.
  - No done pulse; a new accept at the next edge completes correctly with a=2, b=9 -> LO=0x12.
REQ-036 Readout decode: inSignal=ADD (100000) or start with inSignal≠MULTU:
  - dataOut=0.
  - No state change and busy stays 0.
